// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator
// between N requesters; req/ack handshake, registered flags.
module comparator_arbiter #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic [N-1:0]   ack,
  output logic           less,
  output logic           equal,
  output logic           greater,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    ACK
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;

  // First set req bit at or above rr_ptr, wrapping N-1 -> 0
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % N]) begin
        found  = 1'b1;
        winner = IDW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = CMP;
      CMP:     state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      less     <= 1'b0;
      equal    <= 1'b0;
      greater  <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            op_a     <= a_flat[int'(winner)*W +: W];
            op_b     <= b_flat[int'(winner)*W +: W];
            grant_id <= winner;
          end
        end
        CMP: begin
          less    <= (op_a < op_b);
          equal   <= (op_a == op_b);
          greater <= (op_a > op_b);
          ack     <= N'(1) << grant_id;
          rr_ptr  <= (grant_id == IDW'(N-1)) ?
                     '0 : grant_id + 1'b1;
        end
        ACK:     ack <= '0;
        default: ack <= '0;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed table-driven bench for comparator_arbiter plus
// hand sequences for operand stability and mid-compare reset.
module tb_comparator_arbiter;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic [N-1:0]   ack;
  logic           less;
  logic           equal;
  logic           greater;
  logic [IDW-1:0] grant_id;
  logic           busy;

  int n_vec;
  int n_bad;

  comparator_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_flat   (a_flat),
    .b_flat   (b_flat),
    .ack      (ack),
    .less     (less),
    .equal    (equal),
    .greater  (greater),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {less, equal, greater}
  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    int             gid;
    logic [2:0]     flags;
    int             wait_cyc;
    bit             keep;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller has already driven req/operands at a negedge.
  task automatic serve(input string name, input int gid,
                       input logic [2:0] flags, input int wcyc);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (ack == '0 && cnt < 10);
    check({name, " wait"}, cnt, wcyc);
    check({name, " ack"}, 32'(ack), 32'(1) << gid);
    check({name, " flags"}, 32'({less, equal, greater}), 32'(flags));
    check({name, " gid"}, 32'(grant_id), gid);
    check({name, " busy"}, 32'(busy), 1);
  endtask

  task automatic release_req(input string name, input logic [2:0] flags);
    req = '0;
    @(negedge clk);
    check({name, " ack drop"}, 32'(ack), 0);
    check({name, " idle"}, 32'(busy), 0);
    check({name, " hold"}, 32'({less, equal, greater}), 32'(flags));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req = '0;
    a_flat = '0;
    b_flat = '0;

    // Round-robin, A_i = i, B_i = 2, req held
    tbl[0] = '{4'b1111, 16'h3210, 16'h2222, 0, 3'b100, 2, 1};
    tbl[1] = '{4'b1111, 16'h3210, 16'h2222, 1, 3'b100, 3, 1};
    tbl[2] = '{4'b1111, 16'h3210, 16'h2222, 2, 3'b010, 3, 1};
    tbl[3] = '{4'b1111, 16'h3210, 16'h2222, 3, 3'b001, 3, 1};
    tbl[4] = '{4'b1111, 16'h3210, 16'h2222, 0, 3'b100, 3, 0};
    // Single requester 0
    tbl[5] = '{4'b0001, 16'h0008, 16'h0001, 0, 3'b001, 2, 0};
    tbl[6] = '{4'b0001, 16'h0005, 16'h000A, 0, 3'b100, 2, 0};
    tbl[7] = '{4'b0001, 16'h000F, 16'h000F, 0, 3'b010, 2, 0};
    // Requester 1 served, then 0011 wraps from rr_ptr=2 to 0
    tbl[8] = '{4'b0010, 16'h0040, 16'h0030, 1, 3'b001, 2, 0};
    tbl[9] = '{4'b0011, 16'h0092, 16'h0097, 0, 3'b100, 2, 0};

    repeat (3) @(negedge clk);
    check("rst ack", 32'(ack), 0);
    check("rst flags", 32'({less, equal, greater}), 0);
    check("rst busy", 32'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle out",
            32'({ack, less, equal, greater, grant_id, busy}), 0);
    end

    for (int i = 0; i < 10; i++) begin
      req    = tbl[i].req;
      a_flat = tbl[i].a;
      b_flat = tbl[i].b;
      serve($sformatf("v%0d", i), tbl[i].gid, tbl[i].flags,
            tbl[i].wait_cyc);
      if (!tbl[i].keep)
        release_req($sformatf("v%0d", i), tbl[i].flags);
    end

    // Operand change after latch must not affect result
    req    = 4'b0100;
    a_flat = 16'h0100;
    b_flat = 16'h0200;
    @(negedge clk);
    check("stab busy", 32'(busy), 1);
    a_flat = 16'h0F00;
    @(negedge clk);
    check("stab ack", 32'(ack), 32'b0100);
    check("stab flags", 32'({less, equal, greater}), 32'b100);
    check("stab gid", 32'(grant_id), 2);
    release_req("stab", 3'b100);

    // Reset while in CMP for requester 3
    req    = 4'b1000;
    a_flat = 16'h5000;
    b_flat = 16'h1000;
    @(negedge clk);
    check("mid busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid rst out",
          32'({ack, less, equal, greater, grant_id, busy}), 0);
    req = '0;
    repeat (2) begin
      @(negedge clk);
      check("mid rst ack", 32'(ack), 0);
    end
    rst_n = 1'b1;
    // rr_ptr back at 0: 1010 must grant 1 (stale ptr 3 grants 3)
    req    = 4'b1010;
    a_flat = 16'h5030;
    b_flat = 16'h1030;
    serve("post rst ptr", 1, 3'b010, 2);
    release_req("post rst ptr", 3'b010);
    req = 4'b1000;
    serve("post rst r3", 3, 3'b001, 2);
    release_req("post rst r3", 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
